// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train sequencer.
// Holds the FSM state encoding and the default field widths used by the
// top level, the interface and the phase counter.
package pulse_gen_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_OFF  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

endpackage

// File: rtl/pulse_train_sequencer_if.sv
// Host-side bundle of the pulse train sequencer.
// master: host command side (drives config and start/stop/pause, reads status)
// slave : sequencer side (reads config/commands, drives pulse_out and status)
interface pulse_train_sequencer_if
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic [WIDTH-1:0]     cfg_ton;
  logic [WIDTH-1:0]     cfg_toff;
  logic [CNT_WIDTH-1:0] cfg_num;
  logic                 start;
  logic                 stop;
  logic                 pause;
  logic                 pulse_out;
  logic                 busy;
  logic [CNT_WIDTH-1:0] pulse_cnt;
  logic                 done;
  logic                 cfg_err;

  modport master (
    output cfg_ton, cfg_toff, cfg_num, start, stop, pause,
    input  pulse_out, busy, pulse_cnt, done, cfg_err
  );

  modport slave (
    input  cfg_ton, cfg_toff, cfg_num, start, stop, pause,
    output pulse_out, busy, pulse_cnt, done, cfg_err
  );

endinterface

// File: rtl/pulse_phase_counter.sv
// Phase length counter shared by the ON and OFF phases.
// Ports: clk, rst (sync, active-high), clr (return to 0), en (count up),
//        limit (current phase length), tc (count == limit-1, i.e. last cycle
//        of the phase).
module pulse_phase_counter
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign tc = (count == limit - 1'b1);

endmodule

// File: rtl/pulse_train_sequencer.sv
// Sequences ON/OFF discharge-pulse phases for the pulse drive stage.
// Ports: clk, rst (sync, active-high), bus (slave side of
//        pulse_train_sequencer_if: cfg_ton/cfg_toff/cfg_num, start/stop/pause
//        in; pulse_out, busy, pulse_cnt, done, cfg_err out).
//
// state   | meaning
// IDLE    | waiting for an accepted start; outputs quiet
// ON      | pulse_out high, counting the ON phase
// OFF     | pulse_out low, counting the OFF phase
// HOLD    | paused; phase count frozen, ret_phase says where to resume
module pulse_train_sequencer
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  pulse_train_sequencer_if.slave bus
);

  state_t               state, state_nxt, ret_phase, ret_nxt, adv;
  logic [WIDTH-1:0]     ton_l, toff_l, limit;
  logic [CNT_WIDTH-1:0] num_l, pulse_cnt;
  logic                 done_q, err_q, done_nxt, err_nxt;
  logic                 ctr_clr, ctr_en, tc;
  logic                 latch, pcnt_clr, pcnt_inc;
  logic                 cfg_ok, last_pulse;

  assign cfg_ok     = (bus.cfg_ton != '0) && (bus.cfg_toff != '0);
  assign last_pulse = (num_l != '0) && (pulse_cnt == num_l);
  assign limit      = (state == ST_OFF) ? toff_l : ton_l;

  pulse_phase_counter #(.WIDTH(WIDTH)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .limit (limit),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ret_phase <= ST_ON;
      ton_l     <= '0;
      toff_l    <= '0;
      num_l     <= '0;
      pulse_cnt <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_phase <= ret_nxt;
      if (latch) begin
        ton_l  <= bus.cfg_ton;
        toff_l <= bus.cfg_toff;
        num_l  <= bus.cfg_num;
      end
      if (pcnt_clr)      pulse_cnt <= '0;
      else if (pcnt_inc) pulse_cnt <= pulse_cnt + 1'b1;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  // The cycle in which pause is sampled was itself an active ON/OFF cycle, so
  // it still advances the phase (including a phase change); only HOLD cycles
  // are excluded from the count. A pause on the final OFF cycle lets the run
  // complete since nothing would be left to resume.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_phase;
    adv       = state;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    latch     = 1'b0;
    pcnt_clr  = 1'b0;
    pcnt_inc  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop && !bus.pause) begin
          if (cfg_ok) begin
            latch     = 1'b1;
            pcnt_clr  = 1'b1;
            ctr_clr   = 1'b1;
            state_nxt = ST_ON;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_ON, ST_OFF: begin
        if (bus.stop) begin
          ctr_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (state == ST_OFF && tc && last_pulse) begin
          ctr_clr   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          if (tc) begin
            ctr_clr  = 1'b1;
            pcnt_inc = (state == ST_ON);
            adv      = (state == ST_ON) ? ST_OFF : ST_ON;
          end else begin
            ctr_en = 1'b1;
          end
          if (bus.pause) begin
            ret_nxt   = adv;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = adv;
          end
        end
      end
      ST_HOLD: begin
        if (bus.stop) begin
          ctr_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!bus.pause) begin
          state_nxt = ret_phase;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.pulse_out = (state == ST_ON);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.pulse_cnt = pulse_cnt;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_pulse_train_sequencer.sv
module tb_pulse_train_sequencer;
  import pulse_gen_pkg::*;

  localparam int W  = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_train_sequencer_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  pulse_train_sequencer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the ON+OFF period plus a hold flag.
  logic          m_run, m_held, m_done, m_err;
  int            m_pos, m_ton, m_toff, m_num;
  logic [CW-1:0] m_pulses;

  typedef struct {
    logic          start;
    logic [W-1:0]  ton;
    logic [W-1:0]  toff;
    logic [CW-1:0] num;
    logic          e_pulse;
    logic          e_busy;
    logic [CW-1:0] e_cnt;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic s, int ton, int toff, int num,
                              logic p, logic b, int c, logic d, logic e);
    vec_t v;
    v.start = s; v.ton = W'(ton); v.toff = W'(toff); v.num = CW'(num);
    v.e_pulse = p; v.e_busy = b; v.e_cnt = CW'(c); v.e_done = d; v.e_err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic st, input logic p,
                       input int ton, input int toff, input int num);
    rst = r; bus.start = s; bus.stop = st; bus.pause = p;
    bus.cfg_ton = W'(ton); bus.cfg_toff = W'(toff); bus.cfg_num = CW'(num);
  endtask

  task automatic model_step();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_run = 0; m_held = 0; m_pos = 0; m_pulses = '0;
      m_ton = 0; m_toff = 0; m_num = 0;
    end else if (!m_run) begin
      if (bus.start && !bus.stop && !bus.pause) begin
        if (bus.cfg_ton != 0 && bus.cfg_toff != 0) begin
          m_ton = int'(bus.cfg_ton); m_toff = int'(bus.cfg_toff); m_num = int'(bus.cfg_num);
          m_pulses = '0; m_pos = 0; m_run = 1; m_held = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (bus.stop) begin
      m_run = 0; m_held = 0;
    end else if (m_held) begin
      if (!bus.pause) m_held = 0;
    end else begin
      m_pos++;
      if (m_pos == m_ton) m_pulses++;
      if (m_pos == m_ton + m_toff) begin
        if (m_num != 0 && int'(m_pulses) == m_num) begin
          m_run = 0; m_done = 1;
        end else begin
          m_pos = 0;
        end
      end
      if (m_run && bus.pause) m_held = 1;
    end
  endtask

  // Inputs are driven at the falling edge, sampled at the rising edge, and
  // outputs are compared at the following falling edge.
  task automatic cycle();
    logic exp_pulse;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_pulse = m_run && !m_held && (m_pos < m_ton);
    chk("model_pulse_out", bus.pulse_out, exp_pulse);
    chk("model_busy", bus.busy, m_run);
    chk("model_pulse_cnt", bus.pulse_cnt, m_pulses);
    chk("model_done", bus.done, m_done);
    chk("model_cfg_err", bus.cfg_err, m_err);
  endtask

  initial begin
    logic [15:0] pbits;
    int          on_cnt, done_cyc;
    logic        seen_done, got_done;

    tbl[0]  = mk(1, 3, 2, 2, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 3, 2, 2, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 3, 2, 2, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 3, 2, 2, 0, 1, 1, 0, 0);
    tbl[4]  = mk(0, 3, 2, 2, 0, 1, 1, 0, 0);
    tbl[5]  = mk(0, 3, 2, 2, 1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 3, 2, 2, 1, 1, 1, 0, 0);
    tbl[7]  = mk(0, 3, 2, 2, 1, 1, 1, 0, 0);
    tbl[8]  = mk(0, 3, 2, 2, 0, 1, 2, 0, 0);
    tbl[9]  = mk(0, 3, 2, 2, 0, 1, 2, 0, 0);
    tbl[10] = mk(0, 3, 2, 2, 0, 0, 2, 1, 0);
    tbl[11] = mk(0, 3, 2, 2, 0, 0, 2, 0, 0);
    tbl[12] = mk(1, 0, 5, 1, 0, 0, 2, 0, 1);
    tbl[13] = mk(0, 0, 5, 1, 0, 0, 2, 0, 0);
    tbl[14] = mk(1, 5, 0, 1, 0, 0, 2, 0, 1);
    tbl[15] = mk(0, 5, 0, 1, 0, 0, 2, 0, 0);

    m_run = 0; m_held = 0; m_pos = 0; m_pulses = '0; m_ton = 0; m_toff = 0; m_num = 0;
    m_done = 0; m_err = 0;

    drive(1, 1, 0, 0, 7, 7, 7);
    cycle();
    cycle();
    chk("reset_pulse_out", bus.pulse_out, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pulse_cnt", bus.pulse_cnt, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_cfg_err", bus.cfg_err, 0);

    // Basic run and zero-time rejection, row r observed in cycle r+1.
    for (int i = 0; i < 16; i++) begin
      drive(0, tbl[i].start, 0, 0, int'(tbl[i].ton), int'(tbl[i].toff), int'(tbl[i].num));
      cycle();
      chk($sformatf("tbl%0d_pulse_out", i), bus.pulse_out, tbl[i].e_pulse);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_pulse_cnt", i), bus.pulse_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].e_done);
      chk($sformatf("tbl%0d_cfg_err", i), bus.cfg_err, tbl[i].e_err);
    end

    // Stop during a continuous run.
    drive(0, 1, 0, 0, 4, 4, 0);
    cycle();
    seen_done = bus.done;
    for (int r = 1; r <= 5; r++) begin
      drive(0, 0, 0, 0, 4, 4, 0);
      cycle();
      seen_done |= bus.done;
    end
    drive(0, 0, 1, 0, 4, 4, 0);
    cycle();
    seen_done |= bus.done;
    chk("stop_busy", bus.busy, 0);
    chk("stop_pulse_out", bus.pulse_out, 0);
    chk("stop_pulse_cnt", bus.pulse_cnt, 1);
    chk("stop_no_done", seen_done, 0);
    drive(0, 0, 0, 0, 4, 4, 0);
    cycle();

    // Pause in the middle of an ON phase, resumed not restarted.
    pbits = '0; on_cnt = 0; done_cyc = -1;
    for (int r = 0; r < 14; r++) begin
      drive(0, (r == 0), 0, (r >= 2 && r <= 6), 5, 2, 1);
      cycle();
      pbits[r+1] = bus.pulse_out;
      if (bus.pulse_out) on_cnt++;
      if (bus.done) done_cyc = r + 1;
    end
    chk("pause_waveform", pbits, 16'h0706);
    chk("pause_on_cycles", on_cnt, 5);
    chk("pause_done_cycle", done_cyc, 13);

    // Stop and pause together mid-ON: stop wins.
    drive(0, 1, 0, 0, 6, 2, 0);
    cycle();
    drive(0, 0, 0, 0, 6, 2, 0);
    cycle();
    drive(0, 0, 1, 1, 6, 2, 0);
    cycle();
    chk("stop_pause_busy", bus.busy, 0);
    chk("stop_pause_pulse_out", bus.pulse_out, 0);
    drive(0, 0, 0, 0, 6, 2, 0);
    cycle();
    chk("stop_pause_stays_idle", bus.busy, 0);

    // Start held through completion restarts right after done.
    got_done = 0;
    for (int r = 0; r < 20 && !got_done; r++) begin
      drive(0, 1, 0, 0, 2, 1, 1);
      cycle();
      got_done = bus.done;
    end
    chk("held_start_done_seen", got_done, 1);
    chk("held_start_idle_at_done", bus.busy, 0);
    cycle();
    chk("held_start_restart_pulse", bus.pulse_out, 1);
    chk("held_start_restart_busy", bus.busy, 1);
    chk("held_start_restart_cnt", bus.pulse_cnt, 0);
    drive(0, 0, 1, 0, 2, 1, 1);
    cycle();

    // Reset in the middle of an OFF phase, then a fresh run.
    drive(0, 1, 0, 0, 2, 3, 3);
    cycle();
    drive(0, 0, 0, 0, 2, 3, 3);
    cycle();
    cycle();
    chk("midoff_pulse_out", bus.pulse_out, 0);
    chk("midoff_busy", bus.busy, 1);
    chk("midoff_pulse_cnt", bus.pulse_cnt, 1);
    drive(1, 1, 0, 0, 2, 3, 3);
    cycle();
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_pulse_out", bus.pulse_out, 0);
    chk("rst_mid_pulse_cnt", bus.pulse_cnt, 0);
    chk("rst_mid_done", bus.done, 0);
    drive(0, 1, 0, 0, 3, 1, 1);
    cycle();
    chk("rst_fresh_pulse_out", bus.pulse_out, 1);
    chk("rst_fresh_busy", bus.busy, 1);
    chk("rst_fresh_pulse_cnt", bus.pulse_cnt, 0);

    // Randomised stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom % 150) == 0, ($urandom % 3) == 0, ($urandom % 25) == 0,
            ($urandom % 7) == 0, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
